axi4_lite_master_bridge: RTL and testbench
==========================================

Name: axi4_lite_master_bridge

Overview:
Upstream master stage that converts the CPU native memory bus into an AXI4-lite master port for the AXI memory model and other AXI4-lite slaves. It accepts one native request at a time and drives AR/R for reads or AW/W/B for writes. It returns a single-cycle mem_ready with read data. All AXI outputs are registered and stay stable while their valid is high.

Parameters:
TIMEOUT_CYCLES, 1024, watchdog limit in cycles spent outside IDLE; used only when AXI_BRIDGE_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
clk  input  1  clock; all state is updated on the rising edge.
resetn  input  1  asynchronous, active-low reset.
mem_valid  input  1  native request; held high until mem_ready.
mem_instr  input  1  request is an instruction fetch.
mem_addr  input  32  byte address.
mem_wdata  input  32  write data.
mem_wstrb  input  4  byte enables; 4'b0000 means read.
mem_ready  output  1  one-cycle completion pulse.
mem_rdata  output  32  read data; valid while mem_ready=1.
mem_axi_awvalid / mem_axi_awready / mem_axi_awaddr / mem_axi_awprot  out/in/out/out  1/1/32/3  write-address channel.
mem_axi_wvalid / mem_axi_wready / mem_axi_wdata / mem_axi_wstrb  out/in/out/out  1/1/32/4  write-data channel.
mem_axi_bvalid / mem_axi_bready  in/out  1/1  write-response channel.
mem_axi_arvalid / mem_axi_arready / mem_axi_araddr / mem_axi_arprot  out/in/out/out  1/1/32/3  read-address channel.
mem_axi_rvalid / mem_axi_rready / mem_axi_rdata  in/out/in  1/1/32  read-data channel.
bus_error  output  1  sticky watchdog-timeout flag.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE.
  - All AXI valid/ready outputs are 0, mem_ready=0, mem_rdata=0, bus_error=0.
  - All address/data registers are 0.
  - A transaction in flight is dropped silently and is not retried.
- States: IDLE, RADDR, RDATA, WADDR_DATA, WRESP, DONE.
- IDLE:
  - On an edge with mem_valid=1, latch addr, wdata, wstrb and instr.
  - arprot/awprot = {mem_instr, 2'b00}; awprot is always 3'b000 for writes.
  - wstrb==0: set arvalid=1 and go to RADDR.
  - wstrb!=0: set awvalid=1 and wvalid=1, go to WADDR_DATA.
- RADDR: on an edge with arvalid&arready, set arvalid=0 and rready=1, go to RDATA.
- RDATA: on an edge with rvalid&rready, capture rdata into mem_rdata, set rready=0 and mem_ready=1, go to DONE.
- WADDR_DATA:
  - awvalid drops on the edge of its own handshake; wvalid drops on the edge of its own handshake. The two are independent and either order is allowed.
  - Internal aw_done/w_done flags record each handshake.
  - When both handshakes are complete (including both on the same edge): set bready=1 and go to WRESP.
- WRESP: on an edge with bvalid&bready, set bready=0 and mem_ready=1, go to DONE. bresp is not examined.
- DONE:
  - mem_ready is high for exactly this one cycle; next state is IDLE and mem_ready clears.
  - The requester deasserts or changes mem_valid during this cycle; mem_valid is not sampled in DONE.
- Latency:
  - Read: mem_ready rises 3 edges after mem_valid is sampled, given zero-wait arready/rvalid.
  - Write: mem_ready rises 3 edges after mem_valid is sampled, given zero-wait awready/wready/bvalid.
  - Each slave wait cycle adds 1.
- Back-to-back: a new request is accepted no earlier than the edge after DONE, giving a minimum of 1 IDLE cycle between transactions.
- Stability: while any valid output is high, its addr/data/strb/prot are held constant.
- Out-of-phase response: an rvalid or bvalid arriving in any other state is ignored (rready/bready are 0).

Optional Feature:
- AXI_BRIDGE_TIMEOUT_EN defined:
  - A 16-bit counter clears in IDLE and increments each cycle in RADDR/RDATA/WADDR_DATA/WRESP.
  - When it reaches TIMEOUT_CYCLES: all AXI valid/ready outputs go to 0, mem_rdata=32'hDEADBEEF, bus_error=1 (sticky until reset), go to DONE (mem_ready pulse).
- AXI_BRIDGE_TIMEOUT_EN undefined:
  - No counter is instantiated; bus_error is tied to 0 and the bridge waits indefinitely.

Test Plan:
1. Read, addr 0x0000_0100, instr=1, memory word 0x1234_5678, zero-wait slave -> araddr=0x100, arprot=3'b100; mem_ready 3 cycles later with mem_rdata=0x1234_5678.
2. Write 0xA5A5_0F0F, wstrb=4'b0011 to 0x0000_0040; wready 2 cycles before awready -> wvalid drops first, awvalid later; one B handshake; a later read returns low half 0x0F0F.
3. Write with awready and wready in the same cycle, bvalid delayed 4 cycles -> bready held 4 cycles; mem_ready exactly 1 cycle.
4. Back-to-back read then write, mem_valid held continuously -> exactly 1 IDLE cycle between the first mem_ready and the second transaction's awvalid.
5. resetn low while in RDATA with rvalid not yet returned -> rready and mem_ready are 0 immediately (asynchronously); after release, the next read completes normally.
6. With AXI_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held at 0 -> arvalid drops after 16 cycles; mem_ready pulse with 0xDEADBEEF; bus_error=1 and stays 1.

Source files
------------

// File: rtl/axi4_lite_master_bridge.sv
// Native memory bus to AXI4-lite master bridge, one outstanding transaction.
// Optional watchdog timeout enabled by defining AXI_BRIDGE_TIMEOUT_EN.
module axi4_lite_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    output logic        bus_error
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR_DATA, WRESP, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] addr_q;
    logic        aw_done, w_done;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_both, timeout;

    assign ar_hs   = mem_axi_arvalid & mem_axi_arready;
    assign r_hs    = mem_axi_rvalid & mem_axi_rready;
    assign aw_hs   = mem_axi_awvalid & mem_axi_awready;
    assign w_hs    = mem_axi_wvalid & mem_axi_wready;
    assign b_hs    = mem_axi_bvalid & mem_axi_bready;
    // Both write handshakes complete, counting one landing on this very edge.
    assign wr_both = (aw_done | aw_hs) & (w_done | w_hs);

    assign mem_axi_araddr = addr_q;
    assign mem_axi_awaddr = addr_q;
    assign mem_axi_awprot = '0;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        busy;

    assign busy    = (state == RADDR) || (state == RDATA) ||
                     (state == WADDR_DATA) || (state == WRESP);
    assign timeout = busy && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt    <= '0;
            bus_error <= 1'b0;
        end else begin
            wd_cnt <= busy ? wd_cnt + 16'd1 : '0;
            if (timeout)
                bus_error <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (mem_valid) next_state = (mem_wstrb == 4'b0000) ? RADDR : WADDR_DATA;
            RADDR:      if (ar_hs)     next_state = RDATA;
            RDATA:      if (r_hs)      next_state = DONE;
            WADDR_DATA: if (wr_both)   next_state = WRESP;
            WRESP:      if (b_hs)      next_state = DONE;
            DONE:                      next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
        if (timeout)
            next_state = DONE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q          <= '0;
            mem_axi_wdata   <= '0;
            mem_axi_wstrb   <= '0;
            mem_axi_arprot  <= '0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            mem_ready       <= 1'b0;
            mem_rdata       <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: if (mem_valid) begin
                    addr_q         <= mem_addr;
                    mem_axi_wdata  <= mem_wdata;
                    mem_axi_wstrb  <= mem_wstrb;
                    mem_axi_arprot <= {mem_instr, 2'b00};
                    aw_done        <= 1'b0;
                    w_done         <= 1'b0;
                    if (mem_wstrb == 4'b0000) begin
                        mem_axi_arvalid <= 1'b1;
                    end else begin
                        mem_axi_awvalid <= 1'b1;
                        mem_axi_wvalid  <= 1'b1;
                    end
                end
                RADDR: if (ar_hs) begin
                    mem_axi_arvalid <= 1'b0;
                    mem_axi_rready  <= 1'b1;
                end
                RDATA: if (r_hs) begin
                    mem_rdata      <= mem_axi_rdata;
                    mem_axi_rready <= 1'b0;
                    mem_ready      <= 1'b1;
                end
                WADDR_DATA: begin
                    if (aw_hs) begin
                        mem_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        mem_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if (wr_both)
                        mem_axi_bready <= 1'b1;
                end
                WRESP: if (b_hs) begin
                    mem_axi_bready <= 1'b0;
                    mem_ready      <= 1'b1;
                end
                default: ;
            endcase
            // Watchdog abort overrides whatever handshake landed on this edge.
            if (timeout) begin
                mem_axi_arvalid <= 1'b0;
                mem_axi_rready  <= 1'b0;
                mem_axi_awvalid <= 1'b0;
                mem_axi_wvalid  <= 1'b0;
                mem_axi_bready  <= 1'b0;
                mem_rdata       <= 32'hDEADBEEF;
                mem_ready       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Scoreboard bench for axi4_lite_master_bridge with a delay-programmable AXI slave.
module tb_axi4_lite_master_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_axi_awvalid, mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid, mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid, mem_axi_rready;
    logic [31:0] mem_axi_rdata;
    logic        bus_error;

    axi4_lite_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
        .mem_axi_rdata(mem_axi_rdata), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] slv_mem [0:255];
    logic [31:0] ref_mem [0:255];

    // Slave knobs: extra wait cycles before each ready/valid response.
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] ar_addr_lat, aw_addr_lat, w_data_lat;
    logic [2:0]  ar_prot_lat;
    logic [3:0]  w_strb_lat;
    int aw_hs_cyc, w_hs_cyc, aw_rise_cyc, b_count = 0, b_hi = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Slave channel models, all reacting on the falling edge.
    initial begin : ar_slave
        int cnt = 0;
        mem_axi_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_axi_arvalid && !mem_axi_arready) begin
                if (cnt >= ar_wait) begin
                    mem_axi_arready = 1'b1;
                    ar_addr_lat = mem_axi_araddr;
                    ar_prot_lat = mem_axi_arprot;
                end else cnt++;
            end else if (!mem_axi_arvalid) begin
                mem_axi_arready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : r_slave
        int cnt = 0;
        mem_axi_rvalid = 1'b0;
        mem_axi_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_axi_rready && !mem_axi_rvalid) begin
                if (cnt >= r_wait) begin
                    mem_axi_rvalid = 1'b1;
                    mem_axi_rdata  = slv_mem[ar_addr_lat[9:2]];
                end else cnt++;
            end else if (!mem_axi_rready) begin
                mem_axi_rvalid = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : aw_slave
        int cnt = 0;
        bit seen = 0;
        mem_axi_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_axi_awvalid && !seen) begin
                seen = 1;
                aw_rise_cyc = cyc;
            end
            if (mem_axi_awvalid && !mem_axi_awready) begin
                if (cnt >= aw_wait) begin
                    mem_axi_awready = 1'b1;
                    aw_addr_lat = mem_axi_awaddr;
                    aw_hs_cyc = cyc + 1;
                end else cnt++;
            end else if (!mem_axi_awvalid) begin
                mem_axi_awready = 1'b0;
                cnt = 0;
                seen = 0;
            end
        end
    end

    initial begin : w_slave
        int cnt = 0;
        mem_axi_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_axi_wvalid && !mem_axi_wready) begin
                if (cnt >= w_wait) begin
                    mem_axi_wready = 1'b1;
                    w_data_lat = mem_axi_wdata;
                    w_strb_lat = mem_axi_wstrb;
                    w_hs_cyc = cyc + 1;
                end else cnt++;
            end else if (!mem_axi_wvalid) begin
                mem_axi_wready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : b_slave
        int cnt = 0;
        mem_axi_bvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_axi_bready) b_hi++;
            if (mem_axi_bready && !mem_axi_bvalid) begin
                if (cnt >= b_wait) begin
                    mem_axi_bvalid = 1'b1;
                    b_count++;
                    for (int b = 0; b < 4; b++)
                        if (w_strb_lat[b])
                            slv_mem[aw_addr_lat[9:2]][8*b +: 8] = w_data_lat[8*b +: 8];
                end else cnt++;
            end else if (!mem_axi_bready) begin
                mem_axi_bvalid = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("ready_cycle", 32'(cyc), 32'(e.cyc));
                    if (!e.wr) check_eq("rdata", mem_rdata, e.data);
                end
            end
        end
    end

    // lat: edges from the driving negedge's cycle count to the mem_ready edge.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit ins, input int lat,
                          input bit to, input bit hold, output int rdy_cyc);
        exp_t e;
        bit seen = 0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = ins;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = wr ? s : 4'b0000;
        e.wr  = wr;
        e.cyc = cyc + lat;
        e.data = '0;
        if (to) begin
            e.data = 32'hDEADBEEF;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
            e.data = ref_mem[a[9:2]];
        end
        sb_q.push_back(e);
        rdy_cyc = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                seen = 1;
                rdy_cyc = cyc;
            end
        end
        if (!seen) begin
            check_eq("ready_wait", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        if (!hold) mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_pulse", {31'd0, mem_ready}, 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int rc, rc1, bc0;
        bit got_rready;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        slv_mem[32'h100 >> 2] = 32'h1234_5678;
        ref_mem[32'h100 >> 2] = 32'h1234_5678;
        slv_mem[32'h80 >> 2]  = 32'hCAFE_F00D;
        ref_mem[32'h80 >> 2]  = 32'hCAFE_F00D;
        resetn = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs",
                 {24'd0, mem_ready, mem_axi_arvalid, mem_axi_rready, mem_axi_awvalid,
                  mem_axi_wvalid, mem_axi_bready, bus_error, 1'b0}, 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_araddr", mem_axi_araddr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Zero-wait instruction fetch.
        do_req(0, 32'h100, 32'h0, 4'h0, 1, 3, 0, 0, rc);
        check_eq("araddr", ar_addr_lat, 32'h100);
        check_eq("arprot", {29'd0, ar_prot_lat}, 32'd4);

        // Write with W accepted two cycles before AW.
        aw_wait = 2;
        bc0 = b_count;
        do_req(1, 32'h40, 32'hA5A5_0F0F, 4'b0011, 0, 5, 0, 0, rc);
        check_eq("awaddr", aw_addr_lat, 32'h40);
        check_eq("wdata", w_data_lat, 32'hA5A5_0F0F);
        check_eq("wstrb", {28'd0, w_strb_lat}, 32'h3);
        check_eq("awprot", {29'd0, mem_axi_awprot}, 32'd0);
        check_eq("aw_after_w", 32'(aw_hs_cyc - w_hs_cyc), 32'd2);
        check_eq("b_count", 32'(b_count - bc0), 32'd1);
        aw_wait = 0;
        do_req(0, 32'h40, 32'h0, 4'h0, 0, 3, 0, 0, rc);

        // Simultaneous AW/W, slow response.
        b_wait = 3;
        b_hi = 0;
        do_req(1, 32'h44, 32'h1357_9BDF, 4'b1111, 0, 6, 0, 0, rc);
        check_eq("aw_w_same", 32'(aw_hs_cyc), 32'(w_hs_cyc));
        check_eq("bready_cycles", 32'(b_hi), 32'd4);
        b_wait = 0;
        do_req(0, 32'h44, 32'h0, 4'h0, 0, 3, 0, 0, rc);

        // Back-to-back read then write with mem_valid held.
        do_req(0, 32'h80, 32'h0, 4'h0, 0, 3, 0, 1, rc1);
        do_req(1, 32'h84, 32'h0BAD_CAFE, 4'b1100, 0, 3, 0, 0, rc);
        check_eq("b2b_gap", 32'(aw_rise_cyc - rc1), 32'd2);
        do_req(0, 32'h84, 32'h0, 4'h0, 0, 3, 0, 0, rc);

        // Asynchronous reset while waiting for read data.
        r_wait = 50;
        @(negedge clk);
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h100; mem_wstrb = 4'h0;
        got_rready = 0;
        for (int i = 0; i < 20 && !got_rready; i++) begin
            @(negedge clk);
            if (mem_axi_rready) got_rready = 1;
        end
        check_eq("reach_rdata", {31'd0, got_rready}, 32'd1);
        #2;
        resetn = 1'b0;
        mem_valid = 1'b0;
        #1;
        check_eq("async_rst_rready", {31'd0, mem_axi_rready}, 32'd0);
        check_eq("async_rst_ready", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        r_wait = 0;
        resetn = 1'b1;
        do_req(0, 32'h100, 32'h0, 4'h0, 0, 3, 0, 0, rc);

`ifdef AXI_BRIDGE_TIMEOUT_EN
        // Watchdog abort on a stuck read address channel.
        ar_wait = 100000;
        do_req(0, 32'h200, 32'h0, 4'h0, 0, 17, 1, 0, rc);
        check_eq("to_arvalid", {31'd0, mem_axi_arvalid}, 32'd0);
        check_eq("to_bus_error", {31'd0, bus_error}, 32'd1);
        ar_wait = 0;
        do_req(0, 32'h100, 32'h0, 4'h0, 0, 3, 0, 0, rc);
        check_eq("to_sticky", {31'd0, bus_error}, 32'd1);
`else
        check_eq("no_bus_error", {31'd0, bus_error}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
